// File: rtl/ir_rx_fifo.sv
// Manchester IR receiver with 16x oversampling, frame FIFO and CSR access.
// Frames are pushed right-aligned; software pops by writing DATA.
module ir_rx_fifo #(
    parameter logic [3:0]  csr_addr   = 4'h0,
    parameter int unsigned clk_freq   = 100000000,
    parameter int unsigned bit_rate   = 596,
    parameter int unsigned frame_bits = 14,
    parameter int unsigned fifo_aw    = 2,
    parameter bit          rx_invert  = 1'b0
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [14:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
    output logic        rx_irq,
    input  logic        rx
);

    localparam int unsigned Div      = clk_freq / bit_rate / 16;
    localparam logic [15:0] DivM1    = 16'(Div - 1);
    localparam int unsigned Depth    = 2 ** fifo_aw;
    localparam logic [5:0]  LastIdx  = 6'(frame_bits - 1);
    localparam logic [fifo_aw:0] FullLevel = {1'b1, {fifo_aw{1'b0}}};

    typedef enum logic [1:0] {StIdle, StStart, StBits, StGap} state_e;

    logic [15:0] cnt_q, cnt_d;
    logic        tick;
    logic        rx_meta_q, rxs_q;

    state_e      state_q, state_d;
    logic [3:0]  ph_q, ph_d;
    logic [5:0]  idx_q, idx_d;
    logic [31:0] sr_q, sr_d;
    logic        a_q, a_d;
    logic        push, man_err;

    logic [31:0]        mem_q [Depth];
    logic [fifo_aw-1:0] wr_ptr_q, rd_ptr_q;
    logic [fifo_aw:0]   level_q, level_d;
    logic               sel, wr, pop, full, push_ok, ovf_set;

    logic        en_q, en_d, irq_en_q, irq_en_d;
    logic        ovf_q, ovf_d, err_q, err_d;
    logic [7:0]  err_cnt_q, err_cnt_d;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = ^{csr_a[9:2], csr_di[31:18], csr_di[15:2]};

    assign tick  = (cnt_q == 16'd0);
    assign cnt_d = tick ? DivM1 : cnt_q - 16'd1;

    // Receiver: ph counts ticks within a bit cell; samples at quarter points.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        idx_d   = idx_q;
        sr_d    = sr_q;
        a_d     = a_q;
        push    = 1'b0;
        man_err = 1'b0;
        if (!en_q) begin
            state_d = StIdle;
        end else if (tick) begin
            ph_d = ph_q + 4'd1;
            case (state_q)
                StIdle: begin
                    if (rxs_q) begin
                        ph_d    = 4'd8;
                        sr_d    = '0;
                        state_d = StStart;
                    end
                end
                StStart: begin
                    if (ph_q == 4'd12) begin
                        if (!rxs_q) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StBits;
                            idx_d   = 6'd1;
                        end
                    end
                end
                StBits: begin
                    if (ph_q == 4'd4) a_d = rxs_q;
                    if (ph_q == 4'd12) begin
                        if (a_q == rxs_q) begin
                            man_err = 1'b1;
                            state_d = StIdle;
                        end else begin
                            sr_d = {sr_q[30:0], rxs_q};
                            if (idx_q == LastIdx) begin
                                push    = 1'b1;
                                state_d = StGap;
                            end else begin
                                idx_d = idx_q + 6'd1;
                            end
                        end
                    end
                end
                StGap: begin
                    if (!rxs_q) state_d = StIdle;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign sel     = (csr_a[14:10] == {1'b0, csr_addr});
    assign wr      = sel & csr_we;
    assign pop     = wr & (csr_a[1:0] == 2'd0) & (level_q != '0);
    assign full    = (level_q == FullLevel);
    // A same-cycle pop frees the slot the push lands in.
    assign push_ok = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_comb begin
        level_d = level_q;
        if (push_ok && !pop) level_d = level_q + 1'b1;
        else if (!push_ok && pop) level_d = level_q - 1'b1;
    end

    always_comb begin
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (wr && csr_a[1:0] == 2'd1) begin
            if (csr_di[16]) ovf_d = 1'b0;
            if (csr_di[17]) begin
                err_d     = 1'b0;
                err_cnt_d = 8'd0;
            end
        end
        if (wr && csr_a[1:0] == 2'd2) begin
            en_d     = csr_di[0];
            irq_en_d = csr_di[1];
        end
        if (ovf_set) ovf_d = 1'b1;
        if (man_err) begin
            err_d = 1'b1;
            if (err_cnt_d != 8'hff) err_cnt_d = err_cnt_d + 8'd1;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (csr_a[1:0])
                2'd0: rdata = (level_q != '0) ? mem_q[rd_ptr_q] : 32'd0;
                2'd1: begin
                    rdata[fifo_aw:0] = level_q;
                    rdata[15:8]      = err_cnt_q;
                    rdata[16]        = ovf_q;
                    rdata[17]        = err_q;
                end
                2'd2: rdata = {30'd0, irq_en_q, en_q};
                default: rdata = '0;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= sr_d;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q     <= DivM1;
            rx_meta_q <= 1'b0;
            rxs_q     <= 1'b0;
            state_q   <= StIdle;
            ph_q      <= 4'd0;
            idx_q     <= 6'd0;
            sr_q      <= '0;
            a_q       <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            en_q      <= 1'b1;
            irq_en_q  <= 1'b1;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            csr_do    <= '0;
            rx_irq    <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rx_meta_q <= rx ^ rx_invert;
            rxs_q     <= rx_meta_q;
            state_q   <= state_d;
            ph_q      <= ph_d;
            idx_q     <= idx_d;
            sr_q      <= sr_d;
            a_q       <= a_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            level_q   <= level_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            csr_do    <= rdata;
            rx_irq    <= irq_en_q & (level_q != '0);
        end
    end

endmodule

// File: tb/tb_ir_rx_fifo.sv
// Directed bench for ir_rx_fifo: divisor 2, so one bit cell is 32 clocks.
module tb_ir_rx_fifo;

    localparam logic [14:0] Idle = 15'h7C00;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic [14:0] csr_a = Idle;
    logic        csr_we = 1'b0;
    logic [31:0] csr_di = '0;
    logic [31:0] csr_do;
    logic        rx_irq;
    logic        rx = 1'b0;

    int checks = 0;
    int failures = 0;
    logic [31:0] rd;
    logic        found;

    always #5 sys_clk = ~sys_clk;

    ir_rx_fifo #(
        .clk_freq  (3200),
        .bit_rate  (100),
        .frame_bits(14),
        .fifo_aw   (2)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .csr_a    (csr_a),
        .csr_we   (csr_we),
        .csr_di   (csr_di),
        .csr_do   (csr_do),
        .rx_irq   (rx_irq),
        .rx       (rx)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic half(input logic v);
        rx = v;
        repeat (16) @(posedge sys_clk);
        #1;
    endtask

    // Start cell's first half is the idle-low line; bad >= 0 flattens that cell and ends the frame.
    task automatic send_frame(input logic [12:0] d, input int bad);
        @(posedge sys_clk);
        #1;
        half(1'b1);
        for (int i = 12; i >= 0; i--) begin
            if (i == bad) begin
                half(1'b0);
                half(1'b0);
                break;
            end
            half(~d[i]);
            half(d[i]);
        end
        rx = 1'b0;
        repeat (48) @(posedge sys_clk);
        #1;
    endtask

    task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
        @(posedge sys_clk);
        #1;
        csr_a = {13'd0, a};
        @(posedge sys_clk);
        #1;
        d = csr_do;
        csr_a = Idle;
    endtask

    task automatic csr_write(input logic [1:0] a, input logic [31:0] v);
        @(posedge sys_clk);
        #1;
        csr_a  = {13'd0, a};
        csr_di = v;
        csr_we = 1'b1;
        @(posedge sys_clk);
        #1;
        csr_we = 1'b0;
        csr_a  = Idle;
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_do", csr_do, 32'd0);
        check("rst_irq", 32'(rx_irq), 32'd0);
        sys_rst_n = 1'b1;
        csr_read(2'd1, rd); check("rst_status", rd, 32'd0);
        csr_read(2'd2, rd); check("rst_ctrl", rd, 32'd3);
        csr_read(2'd0, rd); check("empty_data", rd, 32'd0);
        @(posedge sys_clk);
        #1;
        csr_a = {5'd1, 8'd0, 2'd2};
        @(posedge sys_clk);
        #1;
        check("unsel_do", csr_do, 32'd0);
        csr_a = Idle;

        // Valid RC5 frame
        send_frame(13'h1A5C, -1);
        csr_read(2'd1, rd); check("rc5_level", rd, 32'd1);
        check("rc5_irq", 32'(rx_irq), 32'd1);
        csr_read(2'd0, rd); check("rc5_data", rd, 32'h0000_1A5C);
        csr_write(2'd0, 32'd0);
        check("irq_hold", 32'(rx_irq), 32'd1);
        @(posedge sys_clk);
        #1;
        check("irq_fall", 32'(rx_irq), 32'd0);
        csr_read(2'd1, rd); check("pop_level", rd, 32'd0);

        // 3-tick glitch, then a valid frame
        @(posedge sys_clk);
        #1;
        rx = 1'b1;
        repeat (6) @(posedge sys_clk);
        #1;
        rx = 1'b0;
        repeat (40) @(posedge sys_clk);
        csr_read(2'd1, rd); check("glitch_status", rd, 32'd0);
        send_frame(13'h0123, -1);
        csr_read(2'd0, rd); check("post_glitch_data", rd, 32'h0000_0123);
        csr_write(2'd0, 32'd0);

        // Manchester error at bit 5
        send_frame(13'h1555, 5);
        csr_read(2'd1, rd); check("err_status", rd, 32'h0002_0100);
        csr_write(2'd1, 32'h0002_0000);
        csr_read(2'd1, rd); check("err_clear", rd, 32'd0);

        // Overflow with depth 4
        for (int k = 1; k <= 5; k++) send_frame(13'(k), -1);
        csr_read(2'd1, rd); check("ovf_status", rd, 32'h0001_0004);
        for (int k = 1; k <= 4; k++) begin
            csr_read(2'd0, rd); check("ovf_order", rd, 32'(k));
            csr_write(2'd0, 32'd0);
        end
        csr_read(2'd1, rd); check("drained", rd, 32'h0001_0000);
        csr_write(2'd1, 32'h0001_0000);
        csr_read(2'd1, rd); check("ovf_clear", rd, 32'd0);

        // Full FIFO: pop in the same cycle as a push
        for (int k = 17; k <= 20; k++) send_frame(13'(k), -1);
        found = 1'b0;
        fork
            send_frame(13'h0015, -1);
            begin
                for (int n = 0; n < 2000 && !found; n++) begin
                    @(negedge sys_clk);
                    if (dut.push) found = 1'b1;
                end
                if (found) begin
                    csr_a  = 15'd0;
                    csr_di = 32'd0;
                    csr_we = 1'b1;
                    @(posedge sys_clk);
                    #1;
                    csr_we = 1'b0;
                    csr_a  = Idle;
                end
            end
        join
        check("push_seen", 32'(found), 32'd1);
        csr_read(2'd1, rd); check("simul_level", rd, 32'd4);
        for (int k = 18; k <= 21; k++) begin
            csr_read(2'd0, rd); check("simul_order", rd, 32'(k));
            csr_write(2'd0, 32'd0);
        end

        // en=0 mid-frame
        send_frame(13'h00AA, -1);
        fork
            send_frame(13'h1FFF, -1);
            begin
                repeat (200) @(posedge sys_clk);
                csr_write(2'd2, 32'd2);
            end
        join
        csr_read(2'd2, rd); check("ctrl_en_off", rd, 32'd2);
        csr_read(2'd1, rd); check("en_kept_level", rd, 32'd1);
        csr_read(2'd0, rd); check("en_kept_data", rd, 32'h0000_00AA);
        csr_write(2'd2, 32'd3);

        // Reset pulse mid-frame
        @(posedge sys_clk);
        #1;
        csr_a = 15'd1;
        @(posedge sys_clk);
        #1;
        check("pre_rst_do", csr_do, 32'd1);
        check("pre_rst_irq", 32'(rx_irq), 32'd1);
        fork
            send_frame(13'h0F0F, -1);
            begin
                repeat (150) @(posedge sys_clk);
                #3;
                sys_rst_n = 1'b0;
                #1;
                check("rst_mid_do", csr_do, 32'd0);
                check("rst_mid_irq", 32'(rx_irq), 32'd0);
            end
        join
        csr_a = Idle;
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        csr_read(2'd1, rd); check("rst_level", rd, 32'd0);
        csr_read(2'd2, rd); check("rst_ctrl2", rd, 32'd3);
        send_frame(13'h0F0F, -1);
        csr_read(2'd0, rd); check("post_rst_data", rd, 32'h0000_0F0F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ir_rx_fifo.md
# ir_rx_fifo

Parametrised, FIFO-buffered infrared remote-control receiver for the CSR bus. It oversamples the demodulated IR line at 16× bit rate and decodes both half-bits of each Manchester cell, rejecting start glitches and invalid cells. Complete frames of configurable length go into a FIFO that software drains through CSR registers. A level interrupt is raised while data is pending.

## Interface
- `csr_addr`, default 4'h0: block select, compared (zero-extended) with `csr_a[14:10]`.
- `clk_freq`, default 100000000: `sys_clk` frequency in Hz.
- `bit_rate`, default 596: bit cells per second. Oversampling divisor = `clk_freq/bit_rate/16`, held in a 16-bit counter.
- `frame_bits`, default 14: bits per frame including the start bit. Legal range 2..33.
- `fifo_aw`, default 2: FIFO depth = 2^`fifo_aw` words.
- `rx_invert`, default 0: 1 inverts `rx` before synchronisation.

Ports:
- `sys_clk` input 1: clock.
- `sys_rst_n` input 1: asynchronous reset, active-low.
- `csr_a` input 15: CSR address.
- `csr_we` input 1: CSR write strobe.
- `csr_di` input 32: CSR write data.
- `csr_do` output 32: registered CSR read data.
- `rx_irq` output 1: registered level interrupt.
- `rx` input 1: demodulated IR line, active-high after optional inversion.

## Operation
- Tick generator: down-counter reloads to divisor−1 and produces `tick` when it reaches 0.
- `rx` (after inversion) passes through a 2-flop synchroniser to give `rxs`.
- Receiver FSM advances only on `tick`. It keeps a 4-bit cell phase `ph`, a bit index and a shift register.
  - IDLE: when `rxs`=1, set `ph`←8 (middle of the start cell) and go to START.
  - START: at `ph`=12, if `rxs`=0 this was a glitch: return to IDLE with no error. Otherwise go to BITS with bit index 1.
  - BITS: at `ph`=4 latch first-half sample `a`. At `ph`=12 take `b`=`rxs`.
    - If `a`==`b`: Manchester error. Set `err` sticky, increment `err_cnt` (8-bit, saturates at 255), go to IDLE.
    - Else shift `b` into the register (first data bit ends in the MSB). After bit `frame_bits`−1, push and go to GAP.
  - GAP: stay until `rxs`=0 is seen on a tick, then go to IDLE.
- Pushed word: `frame_bits`−1 data bits, right-aligned, zero-extended to 32 bits.
- Push when FIFO is full: the frame is dropped and `ovf` sticky is set. Exception: if a pop happens in the same cycle, the push is accepted and level is unchanged.
- CSR registers, selected by `csr_a[1:0]` when `csr_a[14:10]`==`csr_addr`:
  - 0 DATA
    - Read: FIFO head, or 0 when empty.
    - Write (any value): pop. Ignored when empty.
  - 1 STATUS
    - Read: [fifo_aw:0] level, [15:8] `err_cnt`, [16] `ovf`, [17] `err`.
    - Write: bit16=1 clears `ovf`; bit17=1 clears `err` and `err_cnt`.
  - 2 CTRL
    - Read/write: [0] `en` (reset 1), [1] `irq_en` (reset 1).
    - Writing `en`=0 forces the FSM to IDLE on the next cycle. FIFO contents are kept.
  - 3: reads 0; writes ignored.
- `rx_irq` ← `irq_en` & (level≠0).

## Timing
- Every register resets on `sys_rst_n`=0, asynchronously:
  - tick counter → divisor−1;
  - synchroniser flops, FSM (IDLE), FIFO pointers and level, `ovf`, `err`, `err_cnt` → 0;
  - `csr_do` → 0, `rx_irq` → 0;
  - `en` → 1, `irq_en` → 1.
- Reset in the middle of a frame discards the partial frame.
- `csr_do` is valid one cycle after `csr_a` is presented. It is 0 when the block is not selected.
- CSR writes take effect on the next clock edge.
- A push commits on the clock edge of the final `ph`=12 tick. `rx_irq` rises one cycle later.
- After the final pop, `rx_irq` falls one cycle after level reaches 0.
- Line to FSM latency is 2 cycles (synchroniser) plus up to one tick period.

## Test plan
- Default parameters, send a valid RC5 frame with data 13'h1A5C:
  - STATUS level=1 and `rx_irq`=1;
  - DATA reads 0x00001A5C;
  - DATA write pops, level=0, `rx_irq`=0 one cycle later.
- Active pulse of 3 ticks on the idle line: no push, `err`=0, FSM back in IDLE. A following valid frame is received correctly.
- Frame whose bit 5 has no mid-cell transition:
  - `err`=1, `err_cnt`=1, no push;
  - writing STATUS 0x20000 clears both.
- Five valid frames 0x0001..0x0005 with no pops (depth 4):
  - level=4, `ovf`=1;
  - pops return 1,2,3,4 in order.
- FIFO full and a pop in the same cycle as a push: push is accepted, level stays 4, the new word is last out.
- `en`=0 written mid-frame: FSM goes to IDLE, no push, FIFO kept.
- `sys_rst_n` pulsed low mid-frame: `csr_do`=0, `rx_irq`=0, level=0 immediately.
